// File: rtl/kl8e_console_ctrl_pkg.sv
// Shared encodings for the KL8E console: device codes, IOT op codes and
// the rx/tx handshake state encodings.
package pdp8_tty_pkg;
  localparam logic [5:0] DEV_KBD_CODE = 6'o03;
  localparam logic [5:0] DEV_TTY_CODE = 6'o04;

  // keyboard ops (device 03)
  localparam logic [2:0] KCF = 3'd0;
  localparam logic [2:0] KSF = 3'd1;
  localparam logic [2:0] KCC = 3'd2;
  localparam logic [2:0] KRS = 3'd4;
  localparam logic [2:0] KIE = 3'd5;
  localparam logic [2:0] KRB = 3'd6;

  // teleprinter ops (device 04)
  localparam logic [2:0] SPF = 3'd0;
  localparam logic [2:0] TSF = 3'd1;
  localparam logic [2:0] TCF = 3'd2;
  localparam logic [2:0] TPC = 3'd4;
  localparam logic [2:0] SPI = 3'd5;
  localparam logic [2:0] TLS = 3'd6;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_CAP = 2'd2} rx_state_t;
  typedef enum logic [1:0] {T_IDLE = 2'd0, T_REQ = 2'd1, T_SETTLE = 2'd2, T_BUSY = 2'd3} tx_state_t;
endpackage

// File: rtl/kl8e_console_ctrl_tx_seq.sv
// Teleprinter transmit sequencer: one UART transfer in flight, one pending
// character behind it, and a done pulse when the last character drains.
module kl8e_tx_seq
  import pdp8_tty_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] load_data,
  input  logic       tx_ack,
  input  logic       tx_empty,
  output logic       tx_req,
  output logic [7:0] tx_data,
  output logic       done
);
  tx_state_t  state;
  logic [7:0] tx_buf;
  logic       tx_pend;
  logic       resend;
  logic [7:0] next_char;

  // A load landing on the drain cycle counts as pending, so it is sent
  // straight away instead of being lost or raising the flag early.
  assign resend    = tx_pend | start;
  assign next_char = start ? load_data : tx_buf;
  assign done      = (state == T_BUSY) && tx_empty && !resend;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= T_IDLE;
      tx_buf  <= 8'd0;
      tx_pend <= 1'b0;
      tx_req  <= 1'b0;
      tx_data <= 8'd0;
    end else begin
      if (start) tx_buf <= load_data;
      case (state)
        T_IDLE: if (start) begin
          state   <= T_REQ;
          tx_req  <= 1'b1;
          tx_data <= load_data;
        end
        // tx_data is frozen here; the UART samples it only on the ack cycle
        T_REQ: begin
          if (start) tx_pend <= 1'b1;
          if (tx_ack) begin
            tx_req <= 1'b0;
            state  <= T_SETTLE;
          end
        end
        T_SETTLE: begin
          if (start) tx_pend <= 1'b1;
          state <= T_BUSY;
        end
        T_BUSY: begin
          if (tx_empty) begin
            if (resend) begin
              tx_pend <= 1'b0;
              tx_req  <= 1'b1;
              tx_data <= next_char;
              state   <= T_REQ;
            end else begin
              state <= T_IDLE;
            end
          end else if (start) begin
            tx_pend <= 1'b1;
          end
        end
        default: state <= T_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/kl8e_console_ctrl.sv
// KL8E console teletype controller: IOT decode for keyboard/teleprinter,
// flags and interrupt enable, and the UART receive handshake.
module kl8e_console_ctrl
  import pdp8_tty_pkg::*;
#(
  parameter logic [5:0] DEV_KBD      = DEV_KBD_CODE,
  parameter logic [5:0] DEV_TTY      = DEV_TTY_CODE,
  parameter bit         STRIP_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [5:0]  io_select,
  input  logic [2:0]  io_op,
  input  logic [11:0] io_data_in,
  output logic [11:0] io_data_out,
  output logic        io_data_avail,
  output logic        io_clear_ac,
  output logic        io_skip,
  output logic        io_interrupt,
  output logic        tx_req,
  input  logic        tx_ack,
  output logic [7:0]  tx_data,
  input  logic        tx_empty,
  output logic        rx_req,
  input  logic        rx_ack,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data
);
  logic       kbd_sel, tty_sel;
  logic       kbd_flag, tp_flag, ie;
  logic [7:0] kbd_buf;
  logic [7:0] rx_char;
  logic       tx_start, tx_done;
  rx_state_t  rx_state;
  logic       unused_hi_ac;

  assign unused_hi_ac = ^io_data_in[11:8];

  assign kbd_sel = iot && (io_select == DEV_KBD);
  assign tty_sel = iot && (io_select == DEV_TTY);

  assign io_interrupt  = ie & (kbd_flag | tp_flag);
  assign io_data_out   = {4'b0, kbd_buf};
  assign io_data_avail = kbd_sel && (io_op == KRS || io_op == KRB);
  assign io_clear_ac   = kbd_sel && (io_op == KCC || io_op == KRB);
  assign io_skip       = (kbd_sel && io_op == KSF && kbd_flag)
                       || (tty_sel && io_op == TSF && tp_flag)
                       || (tty_sel && io_op == SPI && io_interrupt);

  assign tx_start = tty_sel && (io_op == TPC || io_op == TLS);
  assign rx_char  = STRIP_PARITY ? {1'b0, rx_data[6:0]} : rx_data;

  kl8e_tx_seq u_tx (
    .clk       (clk),
    .reset     (reset),
    .start     (tx_start),
    .load_data (io_data_in[7:0]),
    .tx_ack    (tx_ack),
    .tx_empty  (tx_empty),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .done      (tx_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_flag <= 1'b0;
      tp_flag  <= 1'b0;
      ie       <= 1'b1;
      kbd_buf  <= 8'd0;
      rx_req   <= 1'b0;
      rx_state <= R_IDLE;
    end else begin
      if (kbd_sel && (io_op == KCF || io_op == KCC || io_op == KRB)) kbd_flag <= 1'b0;
      if (kbd_sel && io_op == KIE) ie <= io_data_in[0];
      if (tty_sel && (io_op == TCF || io_op == TLS)) tp_flag <= 1'b0;
      if ((tty_sel && io_op == SPF) || tx_done) tp_flag <= 1'b1;
      // later assignment in R_CAP lets a capture beat a coincident flag clear
      case (rx_state)
        R_IDLE: if (!kbd_flag && !rx_empty) begin
          rx_state <= R_REQ;
          rx_req   <= 1'b1;
        end
        R_REQ: if (rx_ack) begin
          rx_state <= R_CAP;
          rx_req   <= 1'b0;
        end
        R_CAP: begin
          kbd_buf  <= rx_char;
          kbd_flag <= 1'b1;
          rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kl8e_console_ctrl.sv
// Scoreboard bench for kl8e_console_ctrl: a flag-level console model plus a
// UART model drive the DUT; a negedge monitor compares every cycle.
module tb_kl8e_console_ctrl;
  import pdp8_tty_pkg::*;
  localparam bit STRIP = 1'b0;

  logic        clk = 1'b0, reset = 1'b1, iot = 1'b0;
  logic [5:0]  io_select = '0;
  logic [2:0]  io_op = '0;
  logic [11:0] io_data_in = '0;
  logic [11:0] io_data_out;
  logic        io_data_avail, io_clear_ac, io_skip, io_interrupt;
  logic        tx_req, tx_ack = 1'b0, tx_empty = 1'b1;
  logic [7:0]  tx_data;
  logic        rx_req, rx_ack = 1'b0, rx_empty = 1'b1;
  logic [7:0]  rx_data = '0;

  kl8e_console_ctrl #(.DEV_KBD(6'o03), .DEV_TTY(6'o04), .STRIP_PARITY(STRIP)) dut (
    .clk(clk), .reset(reset), .iot(iot), .io_select(io_select), .io_op(io_op),
    .io_data_in(io_data_in), .io_data_out(io_data_out), .io_data_avail(io_data_avail),
    .io_clear_ac(io_clear_ac), .io_skip(io_skip), .io_interrupt(io_interrupt),
    .tx_req(tx_req), .tx_ack(tx_ack), .tx_data(tx_data), .tx_empty(tx_empty),
    .rx_req(rx_req), .rx_ack(rx_ack), .rx_empty(rx_empty), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic irq, rxr, skip, clr, avail;
    logic [11:0] dout;
  } exp_t;

  int         total = 0, bad = 0;
  exp_t       exp_q[$];
  logic [7:0] tx_exp_q[$];
  exp_t       mon_e;

  // console model: flags and buffers only
  bit         m_kbd = 0, m_tp = 0, m_ie = 1, m_busy = 0, m_pend = 0;
  logic [7:0] m_buf = '0;
  int         m_rx_phase = 0;  // 0 none, 1 requesting, 2 capturing

  // UART model
  logic [7:0] rx_src[$];
  int         tx_lc = 0, tx_dly = 0, rx_dly = 0, tx_time = 38;
  bit         tx_active = 0, tx_orphan = 0, rx_cap = 0, rand_time = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("io_interrupt", io_interrupt, mon_e.irq);
      check("rx_req", rx_req, mon_e.rxr);
      check("io_skip", io_skip, mon_e.skip);
      check("io_clear_ac", io_clear_ac, mon_e.clr);
      check("io_data_avail", io_data_avail, mon_e.avail);
      if (mon_e.avail) check("io_data_out", io_data_out, mon_e.dout);
    end
    if (tx_req && tx_ack) begin
      if (tx_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL tx_extra: ack with tx_data %0o, none expected at %0t", tx_data, $time);
      end else begin
        check("tx_data", tx_data, tx_exp_q.pop_front());
      end
    end
  end

  // One clock cycle: drive inputs, push expectations, then advance the model.
  task automatic cycle(input bit rst, input bit do_iot, input logic [5:0] sel,
                       input logic [2:0] op, input logic [11:0] ac);
    exp_t e;
    bit compl, ack_now, rack, cap_now, ksel, tsel, kbd_pre, rx_nonempty;
    logic [7:0] cap_ch;
    reset = rst; iot = do_iot; io_select = sel; io_op = op; io_data_in = ac;
    tx_empty = (tx_lc == 0);
    compl = tx_active && (tx_lc == 0);
    ack_now = 0;
    if (tx_req && !tx_active) begin
      if (tx_dly == 0) ack_now = 1; else tx_dly--;
    end
    tx_ack = ack_now;
    rx_nonempty = (rx_src.size() != 0);
    rx_empty = !rx_nonempty;
    cap_now = rx_cap;
    cap_ch = (cap_now && rx_nonempty) ? rx_src[0] : 8'($urandom);
    rx_data = cap_ch;
    rack = 0;
    if (rx_req && !cap_now && rx_nonempty) begin
      if (rx_dly == 0) rack = 1; else rx_dly--;
    end
    rx_ack = rack;

    ksel = do_iot && sel == 6'o03;
    tsel = do_iot && sel == 6'o04;
    e.irq   = m_ie & (m_kbd | m_tp);
    e.rxr   = (m_rx_phase == 1);
    e.skip  = (ksel && op == KSF && m_kbd) || (tsel && op == TSF && m_tp)
            || (tsel && op == SPI && e.irq);
    e.clr   = ksel && (op == KCC || op == KRB);
    e.avail = ksel && (op == KRS || op == KRB);
    e.dout  = {4'b0, m_buf};
    exp_q.push_back(e);

    @(posedge clk);
    kbd_pre = m_kbd;
    if (rst) begin
      m_kbd = 0; m_tp = 0; m_ie = 1; m_buf = '0; m_busy = 0; m_pend = 0; m_rx_phase = 0;
      tx_exp_q.delete();
      tx_orphan = tx_active && !compl;
    end else begin
      if (ksel && op inside {KCF, KCC, KRB}) m_kbd = 0;
      if (ksel && op == KIE) m_ie = ac[0];
      if (tsel && (op == TCF || op == TLS)) m_tp = 0;
      if (tsel && op == SPF) m_tp = 1;
      if (tsel && (op == TPC || op == TLS)) begin
        if (!m_busy) begin tx_exp_q.push_back(ac[7:0]); m_busy = 1; end
        else if (m_pend) tx_exp_q[tx_exp_q.size()-1] = ac[7:0];
        else begin tx_exp_q.push_back(ac[7:0]); m_pend = 1; end
      end
      if (compl) begin
        if (tx_orphan) tx_orphan = 0;
        else if (m_busy) begin
          if (m_pend) m_pend = 0;
          else begin m_busy = 0; m_tp = 1; end
        end
      end
      case (m_rx_phase)
        0: if (!kbd_pre && rx_nonempty) m_rx_phase = 1;
        1: if (rack) m_rx_phase = 2;
        default: begin
          m_kbd = 1;
          m_buf = STRIP ? {1'b0, cap_ch[6:0]} : cap_ch;
          m_rx_phase = 0;
        end
      endcase
    end
    if (compl) tx_active = 0;
    if (ack_now) begin
      tx_active = 1;
      tx_lc = rand_time ? $urandom_range(1, 8) : tx_time;
      tx_dly = $urandom_range(0, 3);
    end else if (tx_lc > 0) tx_lc--;
    if (cap_now && rx_nonempty) void'(rx_src.pop_front());
    if (rack) rx_dly = $urandom_range(0, 3);
    rx_cap = rack;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 6'd0, 3'd0, 12'd0);
  endtask

  task automatic iotc(input logic [5:0] s, input logic [2:0] o, input logic [11:0] ac);
    cycle(0, 1, s, o, ac);
  endtask

  task automatic wait_tx_idle(input int budget);
    int n = 0;
    while ((m_busy || tx_active) && n < budget) begin idle(1); n++; end
    total++;
    if (m_busy || tx_active) begin bad++; $display("FAIL tx_timeout: print still busy after %0d cycles", budget); end
  endtask

  task automatic wait_kbd(input int budget);
    int n = 0;
    while (!m_kbd && n < budget) begin idle(1); n++; end
    total++;
    if (!m_kbd) begin bad++; $display("FAIL kbd_timeout: no character after %0d cycles", budget); end
  endtask

  initial begin
    bit hit;
    int n;
    logic [5:0] s;
    @(posedge clk); #1;
    cycle(1, 0, 6'd0, 3'd0, 12'd0);
    cycle(0, 0, 6'd0, 3'd0, 12'd0);
    check("tx_req_reset", tx_req, 0);
    check("tx_data_reset", tx_data, 0);
    iotc(6'o03, KRS, 12'd0);

    // keyboard receive, KSF, KRB
    rx_src.push_back(8'o215);
    wait_kbd(50);
    idle(2);
    iotc(6'o03, KSF, 12'd0);
    iotc(6'o03, KRB, 12'o7777);
    iotc(6'o03, KSF, 12'd0);

    // single print with a long UART delay
    iotc(6'o04, TLS, 12'o0301);
    wait_tx_idle(200);
    idle(1);
    iotc(6'o04, TSF, 12'd0);

    // back-to-back prints: second load goes pending
    iotc(6'o04, TLS, 12'o0301);
    idle(3);
    iotc(6'o04, TLS, 12'o0302);
    wait_tx_idle(300);
    idle(2);

    // interrupt enable and SPI
    iotc(6'o04, TCF, 12'd0);
    rx_src.push_back(8'o101);
    wait_kbd(50);
    iotc(6'o03, KIE, 12'd0);
    iotc(6'o04, SPI, 12'd0);
    iotc(6'o03, KIE, 12'd1);
    iotc(6'o04, SPI, 12'd0);

    // held character, then KCF coinciding with capture
    rx_src.push_back(8'o102);
    idle(6);
    iotc(6'o03, KCF, 12'd0);
    hit = 0; n = 0;
    while (!hit && n < 30) begin
      if (m_rx_phase == 2) begin iotc(6'o03, KCF, 12'd0); hit = 1; end
      else idle(1);
      n++;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL kcf_cap: capture cycle not reached"); end
    idle(2);
    iotc(6'o03, KRS, 12'd0);
    iotc(6'o03, KCF, 12'd0);

    // reset in the middle of a print
    tx_time = 20;
    iotc(6'o04, TLS, 12'o0303);
    n = 0;
    while (!(tx_active && tx_lc > 3 && tx_lc < 15) && n < 100) begin idle(1); n++; end
    cycle(1, 0, 6'd0, 3'd0, 12'd0);
    idle(1);
    check("tx_req_after_reset", tx_req, 0);
    iotc(6'o04, TLS, 12'o0304);
    wait_tx_idle(300);
    idle(2);

    // randomized traffic
    rand_time = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0 && rx_src.size() < 3) rx_src.push_back(8'($urandom));
      if ($urandom_range(0, 99) < 35) begin
        case ($urandom_range(0, 4))
          0, 1:    s = 6'o03;
          2, 3:    s = 6'o04;
          default: s = 6'o05;
        endcase
        iotc(s, 3'($urandom), 12'($urandom));
      end else idle(1);
    end
    wait_tx_idle(500);
    idle(2);
    check("tx_drain", tx_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kl8e_console_ctrl.md
Name: kl8e_console_ctrl

Overview:
PDP-8 KL8E-style console teletype controller. It sits between the CPU IOT bus and the UART (tx/rx request-ack handshake ports).
- Decodes keyboard (device 03) and teleprinter (device 04) IOTs.
- Keeps the keyboard and printer flags, the interrupt enable, and the 8-bit rx/tx buffers.
- Sequences the UART handshakes so that only one transfer per direction is in flight.

Parameters:
DEV_KBD, 6'o03, keyboard device select code
DEV_TTY, 6'o04, teleprinter device select code
STRIP_PARITY, 0, 1 = clear bit 7 of received char before buffering

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
iot  in  1  single-cycle IOT strobe from CPU
io_select  in  6  instruction bits 3-8 (device code)
io_op  in  3  instruction bits 9-11
io_data_in  in  12  AC value during strobe
io_data_out  out  12  {4'b0, kbd_buf}, valid when io_data_avail
io_data_avail  out  1  CPU ORs io_data_out into AC
io_clear_ac  out  1  CPU clears AC (applied before OR)
io_skip  out  1  CPU increments PC
io_interrupt  out  1  ie & (kbd_flag | tp_flag)
tx_req  out  1  UART transmit request
tx_ack  in  1  UART accepted tx_data
tx_data  out  8  character to transmit
tx_empty  in  1  UART transmitter idle
rx_req  out  1  UART receive request
rx_ack  in  1  UART accepted rx request
rx_empty  in  1  UART has no character
rx_data  in  8  received char, valid the cycle after rx_ack

Behaviour:
- Reset values:
  - Registers: kbd_flag=0, tp_flag=0, ie=1, kbd_buf=0, tx_buf=0, tx_pend=0.
  - Outputs: tx_req=0, rx_req=0, tx_data=0, io_interrupt=0.
  - FSMs go to IDLE. Reset mid-handshake abandons the transfer; the UART-side state is not restored.
- io_skip, io_clear_ac and io_data_avail are combinational and are asserted only while iot=1 with a matching device. All register updates occur at the clk edge ending the strobe cycle.
- Keyboard IOTs (io_select==DEV_KBD):
  - op0 KCF: kbd_flag<=0
  - op1 KSF: skip if kbd_flag
  - op2 KCC: clear AC, kbd_flag<=0
  - op4 KRS: data_avail
  - op5 KIE: ie<=io_data_in[0]
  - op6 KRB: clear AC, data_avail, kbd_flag<=0
  - op3, op7: no effect
- Teleprinter IOTs (io_select==DEV_TTY):
  - op0 SPF: tp_flag<=1
  - op1 TSF: skip if tp_flag
  - op2 TCF: tp_flag<=0
  - op4 TPC: load tx_buf<=io_data_in[7:0], start print
  - op5 SPI: skip if io_interrupt
  - op6 TLS: tp_flag<=0, load, start print
  - op3, op7: no effect
- RX FSM (R_IDLE, R_REQ, R_CAP):
  - R_IDLE -> R_REQ when kbd_flag==0 and rx_empty==0. rx_req=1 in R_REQ.
  - R_REQ -> R_CAP on rx_ack. rx_req drops in R_CAP.
  - R_CAP: kbd_buf<=rx_data (bit 7 masked if STRIP_PARITY), kbd_flag<=1, -> R_IDLE.
  - While kbd_flag=1, no request is made; the character is held in the UART.
  - If KCF/KCC/KRB coincide with R_CAP, the capture wins and kbd_flag ends at 1.
- TX FSM (T_IDLE, T_REQ, T_SETTLE, T_BUSY):
  - Start print in T_IDLE -> T_REQ; tx_data=tx_buf, tx_req=1 until tx_ack.
  - tx_ack -> T_SETTLE. Wait exactly one cycle, because tx_empty falls the cycle after ack.
  - T_SETTLE -> T_BUSY. T_BUSY -> T_IDLE when tx_empty==1.
  - On exit from T_BUSY: if tx_pend, clear tx_pend and re-enter T_REQ with the current tx_buf; otherwise tp_flag<=1.
  - Start print while not T_IDLE: tx_buf overwritten, tx_pend<=1, tp_flag not set until the pending char completes.
  - A start-print load in T_REQ is sampled by the UART only on the ack cycle, so tx_data must stay stable in T_REQ. Loads arriving during T_REQ go to pending.
  - SPF during a busy print sets tp_flag immediately; completion sets it again.
- io_interrupt is combinational from registers.

Decomposition:
- Package pdp8_tty_pkg:
  - device codes
  - IOT op localparams (KCF..KRB, SPF..TLS)
  - rx/tx state encodings (2 bits each)
- One natural sub-module: kl8e_tx_seq, containing the TX FSM, tx_buf and tx_pend, and producing a done pulse. The RX FSM and IOT decode stay in the top.

Test Plan:
- Reset, then hold rx_empty=0, rx_data=8'o215 -> one rx_req, kbd_flag=1 two cycles after rx_ack, kbd_buf=8'o215. KSF -> io_skip=1. KRB -> io_clear_ac=1, io_data_out=12'o0215, kbd_flag=0.
- TLS with AC=12'o0301 -> tx_req until ack, tx_data=8'o301, tp_flag=0 while the UART delay (38 cycles) runs, tp_flag=1 the cycle after tx_empty returns. TSF then skips.
- Second TLS (AC=12'o0302) during busy -> exactly two tx_acks in order 301, 302, and tp_flag rises only after the second completes.
- KIE with AC=0 while kbd_flag=1 -> io_interrupt=0. KIE with AC=1 -> io_interrupt=1. SPI skips only while ie=1.
- rx_empty=0 with kbd_flag=1 -> no rx_req until KCF. KCF on the R_CAP cycle -> kbd_flag=1.
- Reset asserted in T_BUSY -> tx_req=0, tp_flag=0, FSM idle next cycle, and a new TLS works normally.
